// File: rtl/cnn_mem_pkg.sv
// Shared constants, FSM state type and helpers for the CNN accelerator memory read path.
package cnn_mem_pkg;

  localparam int MEM_ADDR_SIZE = 20;
  localparam int DATA_SIZE     = 16;
  localparam int BLOCK_WORDS   = 25;
  localparam int REQ_IMG       = 0;
  localparam int REQ_FILT      = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } arb_state_t;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker: round-robin from ptr by default,
// fixed lowest-index priority when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import cnn_mem_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_valid && req[i]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
`else
    for (int i = 0; i < N_REQ; i++) begin : scan
      int j;
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_valid && req[j]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(j);
      end
    end
`endif
    if (win_valid) win_onehot[win_idx] = 1'b1;
  end

endmodule

// File: rtl/cnn_mem_read_arbiter.sv
// Shares the accelerator memory read port between block loaders and issues
// block reads until each transfer is covered. Arbitration mode: ARB_FIXED_PRIO_EN.
module cnn_mem_read_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = cnn_mem_pkg::MEM_ADDR_SIZE,
  parameter int LEN_W       = 12,
  parameter int BLOCK_WORDS = cnn_mem_pkg::BLOCK_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic                    beat_valid,
  output logic [LEN_W-1:0]        beat_idx,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack
);
  import cnn_mem_pkg::*;

  localparam int               PTR_W = ptr_width(N_REQ);
  localparam logic [LEN_W-1:0] BW_L  = LEN_W'(BLOCK_WORDS);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              busy_q, busy_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]  beat_idx_q, beat_idx_d;
  logic [LEN_W-1:0]  beats_q, beats_d;

  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              win_valid;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic [LEN_W-1:0]  win_beats;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  assign win_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_len  = req_len[int'(win_idx)*LEN_W +: LEN_W];
  // Quotient plus remainder test avoids the overflow of (len + BLOCK_WORDS - 1).
  assign win_beats = (win_len / BW_L) + LEN_W'((win_len % BW_L) != '0);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    done_d     = '0;
    busy_d     = busy_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    beat_idx_d = beat_idx_q;
    beats_d    = beats_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          owner_d    = win_idx;
          mem_addr_d = win_addr;
          beats_d    = win_beats;
          beat_idx_d = '0;
          busy_d     = 1'b1;
          if (win_beats == '0) begin
            state_d = DONE;
            done_d  = win_onehot;
          end else begin
            state_d  = READ;
            grant_d  = win_onehot;
            mem_rd_d = 1'b1;
          end
        end
      end
      READ: begin
        if (mem_ack) begin
          mem_addr_d = mem_addr_q + ADDR_W'(BLOCK_WORDS);
          beat_idx_d = beat_idx_q + LEN_W'(1);
          if (beat_idx_q == beats_q - LEN_W'(1)) begin
            state_d  = DONE;
            mem_rd_d = 1'b0;
            grant_d  = '0;
            done_d   = grant_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        busy_d   = 1'b0;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      beat_idx_q <= '0;
      beats_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      beat_idx_q <= beat_idx_d;
      beats_q    <= beats_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign beat_idx   = beat_idx_q;
  assign beat_valid = (state_q == READ) && mem_ack;

endmodule
